// File: rtl/seq_divider.sv
// Multi-cycle 32-bit restoring divider, one quotient bit per clock.
// Signed mode divides magnitudes, then fixes the signs of quotient and remainder.
module seq_divider #(
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        ready,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [32:0] p_q;
    logic [31:0] q_q;
    logic [31:0] b_q;
    logic [31:0] a_q;
    logic        sa_q, sb_q;
    logic        zero_q, ovf_q;

    logic [31:0] quot_q, rem_q;
    logic        dbz_q, ovfo_q;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [33:0] shifted, diff;
    logic        take;
    logic [32:0] p_nxt;
    logic [31:0] q_nxt;
    logic [31:0] q_res, r_res;

    assign accept = start && (state_q == IDLE || state_q == DONE);

    assign a_neg = SIGNED_MODE && dividend[31];
    assign b_neg = SIGNED_MODE && divisor[31];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    // P never exceeds the divisor, so the 34-bit trial difference
    // carries the borrow in its top bit.
    assign shifted = {p_q, q_q[31]};
    assign diff    = shifted - {2'b00, b_q};
    assign take    = ~diff[33];
    assign p_nxt   = take ? diff[32:0] : shifted[32:0];
    assign q_nxt   = {q_q[30:0], take};

    assign q_res = (sa_q ^ sb_q) ? -q_q : q_q;
    assign r_res = sa_q ? -p_q[31:0] : p_q[31:0];

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a start in DONE chains directly into a new divide.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CALC;
            CALC: if (cnt_q == 5'd31) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch and shift/trial-subtract iterations.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            p_q    <= '0;
            q_q    <= '0;
            b_q    <= '0;
            a_q    <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            p_q    <= '0;
            q_q    <= a_mag;
            b_q    <= b_mag;
            a_q    <= dividend;
            sa_q   <= a_neg;
            sb_q   <= b_neg;
            zero_q <= (divisor == 32'd0);
            ovf_q  <= SIGNED_MODE
                      && (dividend == 32'h8000_0000)
                      && (divisor == 32'hFFFF_FFFF);
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 5'd1;
            p_q   <= p_nxt;
            q_q   <= q_nxt;
        end
    end

    // Result registers, written once per divide and held afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
            ovfo_q <= 1'b0;
        end else if (state_q == FIX) begin
            if (zero_q) begin
                quot_q <= '0;
                rem_q  <= a_q;
                dbz_q  <= 1'b1;
                ovfo_q <= 1'b0;
            end else if (ovf_q) begin
                quot_q <= 32'h8000_0000;
                rem_q  <= '0;
                dbz_q  <= 1'b0;
                ovfo_q <= 1'b1;
            end else begin
                quot_q <= q_res;
                rem_q  <= r_res;
                dbz_q  <= 1'b0;
                ovfo_q <= 1'b0;
            end
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovfo_q;
    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign ready       = (state_q == DONE);

endmodule
